// File: rtl/display_source_scheduler_pkg.sv
// display_source_scheduler_pkg: shared source count, display limit, FSM state type and clamp helper
package sensor_disp_pkg;
  localparam int NUM_SRC = 4;
  localparam int DEFAULT_MAX_DISP = 9999;
  typedef enum logic [1:0] {IDLE, SELECT, SHOW} state_t;
  function automatic logic [15:0] clamp_disp(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/display_source_scheduler_if.sv
// display_source_scheduler_if: source request/value bundle and display-side outputs
interface display_source_scheduler_if;
  import sensor_disp_pkg::*;
  logic [NUM_SRC-1:0] req;
  logic [15:0] val0;
  logic [15:0] val1;
  logic [15:0] val2;
  logic [15:0] val3;
  logic hold;
  logic [NUM_SRC-1:0] ack;
  logic [15:0] value;
  logic value_valid;
  logic [1:0] src_id;
  logic ovf;
  modport master (output req, val0, val1, val2, val3, hold, input ack, value, value_valid, src_id, ovf);
  modport slave (input req, val0, val1, val2, val3, hold, output ack, value, value_valid, src_id, ovf);
endinterface

// File: rtl/display_source_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first requester after last_grant, wrapping 3->0
module rr_arbiter
  import sensor_disp_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [1:0]         i_last_grant,
  output logic [1:0]         o_grant,
  output logic               o_any_req
);
  logic [1:0] w_idx;
  assign o_any_req = |i_req;
  // scan from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    o_grant = i_last_grant;
    w_idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      w_idx = i_last_grant + 2'(k);
      if (i_req[w_idx]) o_grant = w_idx;
    end
  end
endmodule

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: round-robin rotation of four sources onto a clamped 4-digit display
module display_source_scheduler
  import sensor_disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int MAX_DISP = DEFAULT_MAX_DISP
) (
  input logic fpga_clk1,
  input logic reset,
  display_source_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [15:0] LIM = 16'(MAX_DISP);
  logic [1:0] r_rst_sync;
  logic w_rst_n;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0] r_last, w_last, r_src, w_src, w_grant;
  logic [NUM_SRC-1:0] r_ack, w_ack;
  logic [15:0] r_value, w_value, w_raw;
  logic r_valid, w_valid, r_ovf, w_ovf, w_any, w_exit;
  assign w_rst_n = r_rst_sync[1];
  rr_arbiter u_arb (
    .i_req(bus.req),
    .i_last_grant(r_last),
    .o_grant(w_grant),
    .o_any_req(w_any)
  );
  // reset asserts immediately but releases two clock edges later
  always_ff @(posedge fpga_clk1 or negedge reset)
    if (!reset) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  // next state, dwell counter and grant bookkeeping; dwell ends early if the shown source withdraws
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_last = r_last;
    w_src = r_src;
    w_ack = '0;
    w_exit = !bus.req[r_src] || (!bus.hold && r_cnt == '0);
    case (r_state)
      IDLE: w_next = w_any ? SELECT : IDLE;
      SELECT: begin
        w_next = w_any ? SHOW : IDLE;
        w_src = w_any ? w_grant : r_src;
        w_last = w_any ? w_grant : r_last;
        w_ack = w_any ? NUM_SRC'(1) << w_grant : '0;
        w_cnt = w_any ? CNT_LOAD : r_cnt;
      end
      SHOW: begin
        w_next = w_exit ? (w_any ? SELECT : IDLE) : SHOW;
        w_cnt = (!w_exit && !bus.hold) ? r_cnt - CNT_W'(1) : r_cnt;
      end
      default: w_next = IDLE;
    endcase
    w_raw = (w_src == 2'd0) ? bus.val0 : (w_src == 2'd1) ? bus.val1 : (w_src == 2'd2) ? bus.val2 : bus.val3;
    w_valid = w_next == SHOW;
    w_value = w_valid ? clamp_disp(w_raw, LIM) : '0;
    w_ovf = w_valid && (w_raw > LIM);
  end
  // register state and all display outputs
  always_ff @(posedge fpga_clk1 or negedge w_rst_n)
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_last <= 2'd3;
      r_src <= '0;
      r_ack <= '0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_last <= w_last;
      r_src <= w_src;
      r_ack <= w_ack;
      r_value <= w_value;
      r_valid <= w_valid;
      r_ovf <= w_ovf;
    end
  assign bus.ack = r_ack;
  assign bus.value = r_value;
  assign bus.value_valid = r_valid;
  assign bus.src_id = r_src;
  assign bus.ovf = r_ovf;
endmodule

// File: tb/tb_display_source_scheduler.sv
// tb_display_source_scheduler: scoreboard bench for rotation, clamping, hold, drop and async reset
module tb_display_source_scheduler;
  typedef struct packed {logic [1:0] src; logic [15:0] value; logic ovf;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ack_cyc = 0;
  exp_t sb[$];
  display_source_scheduler_if bus();
  display_source_scheduler #(.DWELL_CYCLES(4)) dut (.fpga_clk1(clk), .reset(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t mk(input logic [1:0] src, input logic [15:0] v);
    return '{src, (v > 16'd9999) ? 16'd9999 : v, v > 16'd9999};
  endfunction
  function automatic logic [23:0] got();
    return {bus.ack, bus.src_id, bus.value, bus.value_valid, bus.ovf};
  endfunction
  function automatic logic [23:0] want(input exp_t e);
    logic [3:0] oh;
    oh = 4'b0001 << e.src;
    return {oh, e.src, e.value, 1'b1, e.ovf};
  endfunction
  task automatic wait_ack(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = |bus.ack;
    end
    if (seen) ack_cyc = cyc;
  endtask
  task automatic test_reset;
    bus.req = '0; bus.val0 = '0; bus.val1 = '0; bus.val2 = '0; bus.val3 = '0; bus.hold = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (got() !== 24'h0) begin failures++; $display("FAIL reset_outputs got=%h required=000000", got()); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (got() !== 24'h0) begin failures++; $display("FAIL idle_outputs got=%h required=000000", got()); end
  endtask
  task automatic test_rotation;
    bit seen;
    exp_t e;
    int prev;
    bus.val0 = 16'd123; bus.val2 = 16'd456; bus.req = 4'b0101;
    prev = cyc;
    for (int i = 0; i < 2; i++) begin sb.push_back(mk(2'd0, 16'd123)); sb.push_back(mk(2'd2, 16'd456)); end
    for (int i = 0; i < 4; i++) begin
      wait_ack(12, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || got() !== want(e)) begin failures++; $display("FAIL rot_grant%0d got=%h required=%h", i, got(), want(e)); end
      checks++;
      if (ack_cyc - prev !== (i == 0 ? 2 : 5)) begin failures++; $display("FAIL rot_gap%0d got=%0d required=%0d", i, ack_cyc - prev, i == 0 ? 2 : 5); end
      prev = ack_cyc;
    end
  endtask
  task automatic test_single_clamp;
    bit seen;
    exp_t e;
    int prev;
    bus.val1 = 16'd10000; bus.req = 4'b0010;
    prev = cyc;
    sb.push_back(mk(2'd1, 16'd10000));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e)) begin failures++; $display("FAIL single_grant got=%h required=%h", got(), want(e)); end
    checks++;
    if (ack_cyc - prev !== 2) begin failures++; $display("FAIL single_latency got=%0d required=2", ack_cyc - prev); end
    prev = ack_cyc;
    @(negedge clk);
    checks++;
    if (bus.ack !== 4'b0 || bus.value !== 16'd9999 || bus.ovf !== 1'b1)
      begin failures++; $display("FAIL single_pulse got ack=%b value=%0d ovf=%b required ack=0000 value=9999 ovf=1", bus.ack, bus.value, bus.ovf); end
    bus.val1 = 16'd42;
    @(negedge clk);
    checks++;
    if (bus.value !== 16'd42 || bus.ovf !== 1'b0 || bus.value_valid !== 1'b1)
      begin failures++; $display("FAIL single_track got value=%0d ovf=%b valid=%b required value=42 ovf=0 valid=1", bus.value, bus.ovf, bus.value_valid); end
    bus.val1 = 16'd10000;
    sb.push_back(mk(2'd1, 16'd10000));
    sb.push_back(mk(2'd1, 16'd10000));
    for (int i = 0; i < 2; i++) begin
      wait_ack(12, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || got() !== want(e)) begin failures++; $display("FAIL regrant%0d got=%h required=%h", i, got(), want(e)); end
      checks++;
      if (ack_cyc - prev !== 5) begin failures++; $display("FAIL regrant_gap%0d got=%0d required=5", i, ack_cyc - prev); end
      prev = ack_cyc;
    end
  endtask
  task automatic test_hold;
    bit seen;
    exp_t e;
    int t0, bad;
    bus.val0 = 16'd123; bus.val2 = 16'd456; bus.req = 4'b0001;
    t0 = cyc;
    sb.push_back(mk(2'd0, 16'd123));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e) || ack_cyc - t0 !== 2) begin failures++; $display("FAIL hold_grant0 got=%h after %0d required=%h after 2", got(), ack_cyc - t0, want(e)); end
    bus.req = 4'b0101;
    repeat (3) @(negedge clk);
    bus.hold = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack !== 4'b0 || bus.value_valid !== 1'b1 || bus.src_id !== 2'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL hold_freeze got %0d bad cycles required 0", bad); end
    bus.hold = 1'b0;
    t0 = cyc;
    sb.push_back(mk(2'd2, 16'd456));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e)) begin failures++; $display("FAIL hold_next got=%h required=%h", got(), want(e)); end
    checks++;
    if (ack_cyc - t0 !== 2) begin failures++; $display("FAIL hold_release_gap got=%0d required=2", ack_cyc - t0); end
  endtask
  task automatic test_drop;
    bit seen;
    exp_t e;
    int t0, bad;
    bus.req = 4'b0001;
    t0 = cyc;
    sb.push_back(mk(2'd0, 16'd123));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e) || ack_cyc - t0 !== 2) begin failures++; $display("FAIL drop_grant0 got=%h after %0d required=%h after 2", got(), ack_cyc - t0, want(e)); end
    bus.val3 = 16'd9999; bus.req = 4'b1000;
    t0 = cyc;
    sb.push_back(mk(2'd3, 16'd9999));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e)) begin failures++; $display("FAIL drop_grant3 got=%h required=%h", got(), want(e)); end
    checks++;
    if (ack_cyc - t0 !== 2) begin failures++; $display("FAIL drop_gap got=%0d required=2", ack_cyc - t0); end
    bus.val3 = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (bus.value !== 16'd9999 || bus.ovf !== 1'b1) begin failures++; $display("FAIL clamp_max got value=%0d ovf=%b required value=9999 ovf=1", bus.value, bus.ovf); end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.value, bus.value_valid, bus.ovf} !== 22'h0)
      begin failures++; $display("FAIL drop_idle got ack=%b value=%0d valid=%b ovf=%b required all 0", bus.ack, bus.value, bus.value_valid, bus.ovf); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ack !== 4'b0 || bus.value_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL idle_stays got %0d bad cycles required 0", bad); end
  endtask
  task automatic test_async_reset;
    bit seen;
    exp_t e;
    int t0;
    bus.val0 = 16'd7; bus.req = 4'b0001;
    t0 = cyc;
    sb.push_back(mk(2'd0, 16'd7));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e) || ack_cyc - t0 !== 2) begin failures++; $display("FAIL ar_grant0 got=%h after %0d required=%h after 2", got(), ack_cyc - t0, want(e)); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (got() !== 24'h0) begin failures++; $display("FAIL async_clear got=%h required=000000", got()); end
    bus.req = 4'b1110; bus.val1 = 16'd55;
    repeat (2) @(negedge clk);
    checks++;
    if (got() !== 24'h0) begin failures++; $display("FAIL reset_held got=%h required=000000", got()); end
    rst_n = 1'b1;
    t0 = cyc;
    sb.push_back(mk(2'd1, 16'd55));
    wait_ack(12, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || got() !== want(e)) begin failures++; $display("FAIL ar_first_grant got=%h required=%h", got(), want(e)); end
    checks++;
    if (ack_cyc - t0 !== 4) begin failures++; $display("FAIL ar_release_gap got=%0d required=4", ack_cyc - t0); end
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_single_clamp();
    test_hold();
    test_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
